// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch for a Y86-64 style core.
// Assembles one instruction over a req/ack byte port and hands it to decode.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [7:0]  imem_data_i,
  input  logic        imem_err_i,
  input  logic        F_stall_i,
  input  logic [3:0]  M_icode_i,
  input  logic        M_cnd_i,
  input  logic [63:0] M_valA_i,
  input  logic [3:0]  W_icode_i,
  input  logic [63:0] W_valM_i,
  output logic [3:0]  f_icode_o,
  output logic [3:0]  f_ifun_o,
  output logic [3:0]  f_rA_o,
  output logic [3:0]  f_rB_o,
  output logic [3:0]  f_stat_o,
  output logic [63:0] f_valC_o,
  output logic [63:0] f_valP_o,
  output logic        f_valid_o,
  output logic        f_busy_o
);

  localparam logic [3:0] STAT_AOK = 4'd1;
  localparam logic [3:0] STAT_HLT = 4'd2;
  localparam logic [3:0] STAT_ADR = 4'd3;
  localparam logic [3:0] STAT_INS = 4'd4;
  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [2:0] {S_BYTE0, S_REGS, S_CONST, S_DONE, S_HALTED} state_t;

  function automatic logic has_regs(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_regs = 1'b1;
      default:                                  has_regs = 1'b0;
    endcase
  endfunction

  function automatic logic has_const(input logic [3:0] ic);
    case (ic)
      4'h3, 4'h4, 4'h5, 4'h7, 4'h8: has_const = 1'b1;
      default:                      has_const = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    instr_len = 4'd1 + (has_regs(ic) ? 4'd1 : 4'd0) + (has_const(ic) ? 4'd8 : 4'd0);
  endfunction

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [63:0] pend_pc_q, pend_pc_d;
  logic [3:0]  icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d, stat_q, stat_d;
  logic [63:0] valc_q, valc_d, valp_q, valp_d;

  logic        fetching, ack, redir;
  logic [63:0] redir_pc;
  logic [3:0]  byte_icode;

  assign fetching   = (state_q == S_BYTE0) || (state_q == S_REGS) || (state_q == S_CONST);
  assign imem_req_o = fetching && !rst_i;
  assign ack        = imem_req_o && imem_ack_i;
  assign byte_icode = imem_data_i[7:4];

  // A mispredicted jump in memory outranks a ret in writeback.
  assign redir    = ((M_icode_i == 4'h7) && !M_cnd_i) || (W_icode_i == 4'h9);
  assign redir_pc = ((M_icode_i == 4'h7) && !M_cnd_i) ? M_valA_i : W_valM_i;

  always_comb begin
    case (state_q)
      S_REGS:  imem_addr_o = pc_q + 64'd1;
      S_CONST: imem_addr_o = pc_q + (has_regs(icode_q) ? 64'd2 : 64'd1) + {61'd0, cnt_q};
      default: imem_addr_o = pc_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    icode_d   = icode_q;
    ifun_d    = ifun_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    stat_d    = stat_q;
    valc_d    = valc_q;
    valp_d    = valp_q;
    if (pend_q) begin
      // Draining an abandoned request: the byte is dropped once it arrives.
      if (ack) begin
        pc_d    = redir ? redir_pc : pend_pc_q;
        state_d = S_BYTE0;
        pend_d  = 1'b0;
      end else if (redir) begin
        pend_pc_d = redir_pc;
      end
    end else if (redir) begin
      if (imem_req_o && !imem_ack_i) begin
        pend_d    = 1'b1;
        pend_pc_d = redir_pc;
      end else begin
        pc_d    = redir_pc;
        state_d = S_BYTE0;
      end
    end else if (ack && imem_err_i) begin
      icode_d = 4'h1;
      ifun_d  = 4'h0;
      ra_d    = REG_NONE;
      rb_d    = REG_NONE;
      valc_d  = 64'd0;
      stat_d  = STAT_ADR;
      state_d = S_DONE;
    end else begin
      case (state_q)
        S_BYTE0: if (ack) begin
          icode_d = byte_icode;
          ifun_d  = imem_data_i[3:0];
          ra_d    = REG_NONE;
          rb_d    = REG_NONE;
          valc_d  = 64'd0;
          cnt_d   = 3'd0;
          valp_d  = pc_q + {60'd0, instr_len(byte_icode)};
          if (byte_icode > 4'hB) begin
            stat_d  = STAT_INS;
            state_d = S_DONE;
          end else begin
            stat_d = (byte_icode == 4'h0) ? STAT_HLT : STAT_AOK;
            if (has_regs(byte_icode))       state_d = S_REGS;
            else if (has_const(byte_icode)) state_d = S_CONST;
            else                            state_d = S_DONE;
          end
        end
        S_REGS: if (ack) begin
          ra_d    = imem_data_i[7:4];
          rb_d    = imem_data_i[3:0];
          state_d = has_const(icode_q) ? S_CONST : S_DONE;
        end
        S_CONST: if (ack) begin
          valc_d[{cnt_q, 3'b000} +: 8] = imem_data_i;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = S_DONE;
        end
        S_DONE: if (!F_stall_i) begin
          if (stat_q == STAT_AOK) begin
            pc_d    = ((icode_q == 4'h7) || (icode_q == 4'h8)) ? valc_q : valp_q;
            state_d = S_BYTE0;
          end else begin
            state_d = S_HALTED;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_BYTE0;
      pc_q      <= RESET_PC;
      cnt_q     <= 3'd0;
      pend_q    <= 1'b0;
      pend_pc_q <= 64'd0;
      icode_q   <= 4'h1;
      ifun_q    <= 4'h0;
      ra_q      <= REG_NONE;
      rb_q      <= REG_NONE;
      stat_q    <= STAT_AOK;
      valc_q    <= 64'd0;
      valp_q    <= 64'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      icode_q   <= icode_d;
      ifun_q    <= ifun_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      stat_q    <= stat_d;
      valc_q    <= valc_d;
      valp_q    <= valp_d;
    end
  end

  assign f_icode_o = icode_q;
  assign f_ifun_o  = ifun_q;
  assign f_rA_o    = ra_q;
  assign f_rB_o    = rb_q;
  assign f_stat_o  = stat_q;
  assign f_valC_o  = valc_q;
  assign f_valP_o  = valp_q;
  assign f_valid_o = (state_q == S_DONE);
  assign f_busy_o  = !f_valid_o;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, first fetch address after reset.
REQ-002 clk_i  in  1  single clock; all state changes on posedge.
REQ-003 rst_i  in  1  synchronous, active-high reset.
REQ-004 imem_req_o / imem_addr_o  out  1/64  byte read request, address.
REQ-005 imem_ack_i / imem_data_i / imem_err_i  in  1/8/1  byte returned, data, address error; valid only when ack.
REQ-006 F_stall_i  in  1  hold completed instruction, do not advance.
REQ-007 M_icode_i / M_cnd_i / M_valA_i  in  4/1/64  mispredict redirect source.
REQ-008 W_icode_i / W_valM_i  in  4/64  ret redirect source.
REQ-009 f_icode_o, f_ifun_o, f_rA_o, f_rB_o, f_stat_o  out  4 each; f_valC_o, f_valP_o  out  64 each: decoded instruction toward the decode register.
REQ-010 f_valid_o  out  1  f_* hold a completed instruction; f_busy_o  out  1  = ~f_valid_o.

Function
REQ-011 Byte-serial fetch over req/ack: imem_req_o and imem_addr_o SHALL stay stable until imem_ack_i; one byte per ack; zero-wait memory (ack in the req cycle) SHALL be supported.
REQ-012 FSM states: BYTE0, REGS, CONST, DONE, HALTED.
REQ-013 BYTE0: fetch at pc; icode = byte[7:4], ifun = byte[3:0].
REQ-014 Length by icode: 0,1,9 -> 1 byte; 2,6,A,B -> 2 (BYTE0, REGS); 7,8 -> 9 (BYTE0, CONST x8); 3,4,5 -> 10 (BYTE0, REGS, CONST x8).
REQ-015 REGS byte: rA = [7:4], rB = [3:0]; without REGS, rA = rB = 4'hF.
REQ-016 CONST: 8 bytes little-endian (first byte -> valC[7:0]); 3-bit counter; without CONST, valC = 0.
REQ-017 valP = pc + length, modulo 2^64 (wrap permitted, no error).
REQ-018 icode > 4'hB: stat SINS (4), length 1; icode 0: stat SHLT (2); otherwise SAOK (1).
REQ-019 imem_err_i on any ack: abort, f_icode = 4'h1, rA = rB = 4'hF, valC = 0, stat SADR (3), go DONE.
REQ-020 DONE: f_valid_o = 1 for every DONE cycle; F_stall_i = 1 holds all f_* and pc unchanged.
REQ-021 DONE with F_stall_i = 0, stat SAOK: pc <= valC if icode is 7 or 8, else valP; next state BYTE0.
REQ-022 DONE with F_stall_i = 0, stat not SAOK: next state HALTED, no requests.
REQ-023 Redirect priority: M_icode_i == 7 and M_cnd_i == 0 -> M_valA_i; else W_icode_i == 9 -> W_valM_i.
REQ-024 Redirect in any state: partial instruction discarded, f_valid_o = 0 next cycle, pc <= redirect target, next state BYTE0. This applies in HALTED and in DONE, and overrides F_stall_i.
REQ-025 Redirect while a request is unacked: latch target in a pending register, keep req stable until ack, drop the byte, then restart at the pending target. A later redirect overwrites the pending target.
REQ-026 Zero-wait latency: an n-byte instruction gives f_valid_o n cycles after its BYTE0 request cycle, so cycle n+1 of the fetch.

Reset
REQ-027 While rst_i = 1:
- pc = RESET_PC, state BYTE0, pending cleared.
- imem_req_o = 0, f_valid_o = 0, f_busy_o = 1.
- f_icode_o = 4'h1, f_ifun_o = 0, f_rA_o = f_rB_o = 4'hF, f_valC_o = f_valP_o = 0, f_stat_o = SAOK.
REQ-028 First request SHALL occur in the first cycle after rst_i falls.
REQ-029 Reset mid-fetch or mid-wait SHALL abandon everything. A late ack arriving after reset is ignored.

Verification
REQ-030 Zero-wait memory, RESET_PC 0, bytes 30 F2 0A 00.. (irmovq $10,%rdx) -> after 10 acks: icode 3, rA F, rB 2, valC 10, valP 10, valid 1 cycle, next req addr 10.
REQ-031 Bytes 70 00 01 00.. at pc 0 (jmp 0x100), then M_icode 7, M_cnd 0, M_valA 9 asserted during fetch at 0x100 with ack delayed -> req held, byte dropped, next req addr 9, no valid for the aborted instruction.
REQ-032 Instruction complete, F_stall_i high 3 cycles -> f_* and imem_req_o = 0 held; advance on the 4th cycle.
REQ-033 Byte 00 (halt) -> stat 2, valid, then HALTED with no req. W_icode 9, W_valM 0x40 -> req at 0x40.
REQ-034 Byte F0 -> stat 4, valP = pc+1. imem_err_i on 3rd byte of irmovq -> icode 1, stat 3, HALTED.
REQ-035 rst_i pulsed while waiting on ack for CONST byte 5 -> outputs at reset values, restart at RESET_PC.
